fault_recovery_sequencer: RTL and testbench
===========================================

// Module: fault_recovery_sequencer
// PURPOSE
//  In-core responder to fault-recovery requests raised by the fault-injection checker.
//  Latches a request and waits for the core to quiesce (exception taken, store queue empty).
//  Then flushes the pipeline, reloads NUM_REGS architectural registers from the golden state
//  source into the RF, and handshakes a memory sync.
//  Finally hands the restart PC back to fetch.
// PARAMETERS
//  PC_W       64  width of PCs
//  DATA_W     64  width of register data
//  NUM_REGS   34  logical registers to restore (GPRs + LO + HI), indices 0..NUM_REGS-1
//  STQ_CNT_W  5   width of store-queue occupancy count
//  IDX_W      6   width of register index, >= clog2(NUM_REGS)
// PORTS
//  clk            in   1          clock, all state on posedge
//  reset_n        in   1          synchronous active-low reset
//  recovery_req   in   1          one-cycle request from checker (fault propagated / braindead)
//  commit_valid   in   1          an instruction retired this cycle
//  commit_pc      in   PC_W       architectural next-PC after that retirement
//  exception_flag in   1          core has taken the flush exception
//  stq_count      in   STQ_CNT_W  store-queue occupancy
//  flush_o        out  1          one-cycle pipeline flush pulse
//  arch_rd_req    out  1          one-cycle read request to golden state source
//  arch_rd_idx    out  IDX_W      register index of that request
//  arch_rd_valid  in   1          read data returned (>=1 cycle after arch_rd_req)
//  arch_rd_data   in   DATA_W     returned register value
//  rf_we          out  1          architectural RF write enable
//  rf_waddr       out  IDX_W      RF write index
//  rf_wdata       out  DATA_W     RF write data
//  mem_sync_req   out  1          level request: copy golden memory image
//  mem_sync_ack   in   1          one-cycle completion of memory sync
//  restart_valid  out  1          one-cycle pulse: restart fetch at restart_pc
//  restart_pc     out  PC_W       restart PC, stable from restart_valid until next request
//  busy           out  1          state != IDLE
//  double_fault   out  1          one-cycle pulse: request arrived while one already pending
// BEHAVIOUR
//  Reset (reset_n==0 at posedge): state=IDLE.
//   - All outputs 0 on the next cycle; restart_pc=0; index counter=0.
//   - Reset mid-operation abandons the sequence: no write, no sync, no restart.
//  pc_hold register: loads commit_pc whenever commit_valid is 1 in IDLE or PENDING.
//   - Frozen from entry to FLUSH; restart_pc <= pc_hold on entering DONE.
//  States:
//   - IDLE: recovery_req -> PENDING. If commit_valid in the same cycle, pc_hold takes commit_pc.
//   - PENDING: when exception_flag && stq_count==0 -> FLUSH. recovery_req here -> double_fault
//     pulse next cycle; the request is dropped and the state is unchanged.
//   - FLUSH: flush_o=1 this cycle only; idx<=0 -> RD_ISSUE.
//   - RD_ISSUE: arch_rd_req=1 with arch_rd_idx=idx, one cycle only -> RD_WAIT.
//   - RD_WAIT: on arch_rd_valid, register data. Next cycle: rf_we=1, rf_waddr=idx,
//     rf_wdata=data.
//       - If idx==NUM_REGS-1 -> MEM_SYNC; else idx+1 -> RD_ISSUE.
//       - At most one read outstanding. arch_rd_valid outside RD_WAIT is ignored.
//   - MEM_SYNC: mem_sync_req held 1 until mem_sync_ack; ack -> DONE.
//     mem_sync_req is 0 in the cycle after ack.
//   - DONE: restart_valid=1 for one cycle -> IDLE.
//  recovery_req in any state after PENDING through DONE -> double_fault pulse; request dropped.
//  Per-register cost with 1-cycle read latency: 3 cycles.
//   - Req to restart_valid (quiesced, 1-cycle latency/ack): 1+1+3*NUM_REGS+2+1 cycles.
//  Index counter never wraps: it stops at NUM_REGS-1.
// TESTING
//  1. Reset: hold reset_n=0 for 3 cycles, then release.
//     -> all outputs 0; busy=0.
//  2. Basic recovery: commit_pc=0x400100 with commit_valid, then recovery_req.
//     exception_flag=1 with stq_count=2 for 4 cycles, then stq_count=0.
//     Golden data = 0xA000+idx with 1-cycle latency; ack 1 cycle after mem_sync_req.
//     -> flush_o 1 cycle after stq_count hits 0; 34 writes idx 0..33 with data 0xA000..0xA021.
//     -> restart_valid with restart_pc=0x400100.
//  3. Variable latency: arch_rd_valid delay 1..5 cycles random.
//     -> writes in order, no second arch_rd_req before valid.
//  4. Double fault: second recovery_req 2 cycles after the first (PENDING).
//     Another during RD_WAIT.
//     -> double_fault pulses twice; exactly one restart_valid.
//  5. Reset mid-RESTORE: reset_n=0 after write of idx 10.
//     -> no further rf_we, no mem_sync_req, no restart_valid; busy=0.
//  6. PC tracking: commits 0x400200, 0x400204 while PENDING; a commit after FLUSH at 0x400300.
//     -> restart_pc=0x400204.

Source files
------------

// File: rtl/fault_recovery_sequencer.sv
// fault_recovery_sequencer
// Responds to a fault-recovery request: waits for the core to quiesce, flushes
// the pipeline, restores the architectural registers from the golden state
// source one at a time, synchronises memory, then hands the restart PC to fetch.
module fault_recovery_sequencer #(
    parameter int PC_W      = 64,
    parameter int DATA_W    = 64,
    parameter int NUM_REGS  = 34,
    parameter int STQ_CNT_W = 5,
    parameter int IDX_W     = 6
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 recovery_req,
    input  logic                 commit_valid,
    input  logic [PC_W-1:0]      commit_pc,
    input  logic                 exception_flag,
    input  logic [STQ_CNT_W-1:0] stq_count,
    output logic                 flush_o,
    output logic                 arch_rd_req,
    output logic [IDX_W-1:0]     arch_rd_idx,
    input  logic                 arch_rd_valid,
    input  logic [DATA_W-1:0]    arch_rd_data,
    output logic                 rf_we,
    output logic [IDX_W-1:0]     rf_waddr,
    output logic [DATA_W-1:0]    rf_wdata,
    output logic                 mem_sync_req,
    input  logic                 mem_sync_ack,
    output logic                 restart_valid,
    output logic [PC_W-1:0]      restart_pc,
    output logic                 busy,
    output logic                 double_fault
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PENDING,
        S_FLUSH,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_RF_WRITE,
        S_MEM_SYNC,
        S_DONE
    } state_t;

    // Highest register index; the restore loop ends here instead of wrapping.
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [PC_W-1:0]     pc_hold_q, pc_hold_d;
    logic [PC_W-1:0]     restart_pc_q, restart_pc_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                dfault_q, dfault_d;

    // Next-state, counter, PC tracking and Moore-style outputs.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        pc_hold_d    = pc_hold_q;
        restart_pc_d = restart_pc_q;
        rd_data_d    = rd_data_q;
        // Any request while a recovery is already in flight is dropped and flagged.
        dfault_d     = recovery_req && (state_q != S_IDLE);

        flush_o       = 1'b0;
        arch_rd_req   = 1'b0;
        arch_rd_idx   = '0;
        rf_we         = 1'b0;
        rf_waddr      = '0;
        rf_wdata      = '0;
        mem_sync_req  = 1'b0;
        restart_valid = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (commit_valid) begin
                    pc_hold_d = commit_pc;
                end
                if (recovery_req) begin
                    state_d = S_PENDING;
                end
            end
            S_PENDING: begin
                // Retirements still land until the core has quiesced.
                if (commit_valid) begin
                    pc_hold_d = commit_pc;
                end
                if (exception_flag && (stq_count == '0)) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                flush_o = 1'b1;
                idx_d   = '0;
                state_d = S_RD_ISSUE;
            end
            S_RD_ISSUE: begin
                arch_rd_req = 1'b1;
                arch_rd_idx = idx_q;
                state_d     = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                // Only a return seen here is accepted; stray returns elsewhere are ignored.
                if (arch_rd_valid) begin
                    rd_data_d = arch_rd_data;
                    state_d   = S_RF_WRITE;
                end
            end
            S_RF_WRITE: begin
                rf_we    = 1'b1;
                rf_waddr = idx_q;
                rf_wdata = rd_data_q;
                if (idx_q == LAST_IDX) begin
                    state_d = S_MEM_SYNC;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_RD_ISSUE;
                end
            end
            S_MEM_SYNC: begin
                mem_sync_req = 1'b1;
                if (mem_sync_ack) begin
                    restart_pc_d = pc_hold_q;
                    state_d      = S_DONE;
                end
            end
            S_DONE: begin
                restart_valid = 1'b1;
                state_d       = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state, index counter, PC capture and double-fault flag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            pc_hold_q    <= '0;
            restart_pc_q <= '0;
            dfault_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            pc_hold_q    <= pc_hold_d;
            restart_pc_q <= restart_pc_d;
            dfault_q     <= dfault_d;
        end
    end

    // Returned register value; only ever observed through the gated write port.
    always_ff @(posedge clk) begin
        rd_data_q <= rd_data_d;
    end

    assign restart_pc   = restart_pc_q;
    assign busy         = (state_q != S_IDLE);
    assign double_fault = dfault_q;

endmodule

// File: tb/tb_fault_recovery_sequencer.sv
// tb_fault_recovery_sequencer
// Cycle-accurate vector table for reset, quiesce, first register restore and a
// mid-restore reset, followed by directed multi-cycle recovery sequences.
module tb_fault_recovery_sequencer;

    localparam int PC_W      = 64;
    localparam int DATA_W    = 64;
    localparam int NUM_REGS  = 34;
    localparam int STQ_CNT_W = 5;
    localparam int IDX_W     = 6;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 recovery_req;
    logic                 commit_valid;
    logic [PC_W-1:0]      commit_pc;
    logic                 exception_flag;
    logic [STQ_CNT_W-1:0] stq_count;
    logic                 flush_o;
    logic                 arch_rd_req;
    logic [IDX_W-1:0]     arch_rd_idx;
    logic                 arch_rd_valid;
    logic [DATA_W-1:0]    arch_rd_data;
    logic                 rf_we;
    logic [IDX_W-1:0]     rf_waddr;
    logic [DATA_W-1:0]    rf_wdata;
    logic                 mem_sync_req;
    logic                 mem_sync_ack;
    logic                 restart_valid;
    logic [PC_W-1:0]      restart_pc;
    logic                 busy;
    logic                 double_fault;

    always #5 clk = ~clk;

    fault_recovery_sequencer #(
        .PC_W(PC_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS),
        .STQ_CNT_W(STQ_CNT_W), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .recovery_req(recovery_req),
        .commit_valid(commit_valid), .commit_pc(commit_pc),
        .exception_flag(exception_flag), .stq_count(stq_count),
        .flush_o(flush_o), .arch_rd_req(arch_rd_req), .arch_rd_idx(arch_rd_idx),
        .arch_rd_valid(arch_rd_valid), .arch_rd_data(arch_rd_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .mem_sync_req(mem_sync_req), .mem_sync_ack(mem_sync_ack),
        .restart_valid(restart_valid), .restart_pc(restart_pc),
        .busy(busy), .double_fault(double_fault)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Golden-source and memory-ack responders, muxed with direct table drive.
    logic              gold_en = 1'b0;
    logic              ack_en  = 1'b0;
    logic              lat_rand = 1'b0;
    int                lat_fixed = 1;
    logic              t_rdv = 1'b0;
    logic [DATA_W-1:0] t_rdd = '0;
    logic              g_rdv = 1'b0;
    logic [DATA_W-1:0] g_rdd = '0;
    logic              g_ack = 1'b0;
    logic [IDX_W-1:0]  g_idx;
    int                g_lat;

    assign arch_rd_valid = gold_en ? g_rdv : t_rdv;
    assign arch_rd_data  = gold_en ? g_rdd : t_rdd;
    assign mem_sync_ack  = ack_en & g_ack;

    initial begin
        forever begin
            @(negedge clk);
            if (gold_en && arch_rd_req) begin
                g_idx = arch_rd_idx;
                g_lat = lat_rand ? int'($urandom_range(1, 5)) : lat_fixed;
                repeat (g_lat) @(posedge clk);
                #1;
                g_rdv = 1'b1;
                g_rdd = 64'hA000 + 64'(g_idx);
                @(posedge clk);
                #1;
                g_rdv = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (ack_en && mem_sync_req) begin
                @(posedge clk);
                #1 g_ack = 1'b1;
                @(posedge clk);
                #1 g_ack = 1'b0;
            end
        end
    end

    // Observation of DUT activity, sampled on the falling edge.
    logic [IDX_W-1:0]  wr_addr_q[$];
    logic [DATA_W-1:0] wr_data_q[$];
    int                n_restart = 0, n_df = 0, n_flush = 0, n_ms = 0, n_rdviol = 0;
    int                flush_cyc = 0, restart_cyc = 0;
    logic [PC_W-1:0]   last_rpc = '0;
    logic              outstanding = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (rf_we) begin
                wr_addr_q.push_back(rf_waddr);
                wr_data_q.push_back(rf_wdata);
                outstanding = 1'b0;
            end
            if (!busy) outstanding = 1'b0;
            if (arch_rd_req) begin
                if (outstanding) n_rdviol++;
                outstanding = 1'b1;
            end
            if (restart_valid) begin
                n_restart++;
                last_rpc    = restart_pc;
                restart_cyc = cyc;
            end
            if (double_fault) n_df++;
            if (flush_o) begin
                n_flush++;
                flush_cyc = cyc;
            end
            if (mem_sync_req) n_ms++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, cycles=%0d required<50000", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_w(input string name, input logic [146:0] act, input logic [146:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_restart(input int budget, input int start, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (n_restart != start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_writes(input int start, input string tag);
        int errs;
        int n;
        errs = 0;
        n = wr_addr_q.size() - start;
        for (int i = 0; i < n; i++) begin
            if (wr_addr_q[start+i] !== IDX_W'(i)) errs++;
            if (wr_data_q[start+i] !== (64'hA000 + 64'(i))) errs++;
        end
        chk({tag, "_write_count"}, 64'(n), 64'(NUM_REGS));
        chk({tag, "_write_order_errs"}, 64'(errs), 64'd0);
    endtask

    // Inputs driven in a cycle; expected outputs are those visible in that same cycle.
    typedef struct {
        logic              rst_n, req, cv;
        logic [PC_W-1:0]   cpc;
        logic              exc;
        logic [4:0]        stq;
        logic              rdv;
        logic [DATA_W-1:0] rdd;
        logic              e_flush, e_rdreq;
        logic [IDX_W-1:0]  e_idx;
        logic              e_we;
        logic [IDX_W-1:0]  e_waddr;
        logic [DATA_W-1:0] e_wdata;
        logic              e_busy, e_df;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic q, input logic c, input logic [63:0] p,
                       input logic e, input logic [4:0] s, input logic v, input logic [63:0] d,
                       input logic ef, input logic er, input logic [5:0] ei, input logic ew,
                       input logic [5:0] ea, input logic [63:0] ed, input logic eb, input logic edf);
        vec_t t;
        t.rst_n = r; t.req = q; t.cv = c; t.cpc = p; t.exc = e; t.stq = s;
        t.rdv = v; t.rdd = d; t.e_flush = ef; t.e_rdreq = er; t.e_idx = ei;
        t.e_we = ew; t.e_waddr = ea; t.e_wdata = ed; t.e_busy = eb; t.e_df = edf;
        vq.push_back(t);
    endtask

    initial begin
        logic             ok;
        logic             found;
        int               w0, r0, df0, f0, m0, v0, s_cyc;
        logic [146:0]     act, exp;

        reset_n = 1'b0; recovery_req = 1'b0; commit_valid = 1'b0; commit_pc = '0;
        exception_flag = 1'b0; stq_count = '0;

        //   rst req cv cpc        exc stq rdv rdd       | flush rdreq idx we waddr wdata     busy df
        add(0, 0, 0, 64'h0,      0, 0, 0, 64'h0,       0, 0, 0, 0, 0, 64'h0,    0, 0);
        add(0, 0, 0, 64'h0,      0, 0, 0, 64'h0,       0, 0, 0, 0, 0, 64'h0,    0, 0);
        add(0, 0, 0, 64'h0,      0, 0, 0, 64'h0,       0, 0, 0, 0, 0, 64'h0,    0, 0);
        add(1, 0, 1, 64'h400100, 0, 0, 0, 64'h0,       0, 0, 0, 0, 0, 64'h0,    0, 0);
        add(1, 1, 0, 64'h0,      0, 0, 0, 64'h0,       0, 0, 0, 0, 0, 64'h0,    0, 0);
        add(1, 0, 0, 64'h0,      1, 2, 0, 64'h0,       0, 0, 0, 0, 0, 64'h0,    1, 0);
        add(1, 1, 0, 64'h0,      1, 2, 0, 64'h0,       0, 0, 0, 0, 0, 64'h0,    1, 0);
        add(1, 0, 0, 64'h0,      1, 2, 0, 64'h0,       0, 0, 0, 0, 0, 64'h0,    1, 1);
        add(1, 0, 0, 64'h0,      1, 0, 0, 64'h0,       0, 0, 0, 0, 0, 64'h0,    1, 0);
        add(1, 0, 0, 64'h0,      0, 0, 0, 64'h0,       1, 0, 0, 0, 0, 64'h0,    1, 0);
        add(1, 0, 0, 64'h0,      0, 0, 0, 64'h0,       0, 1, 0, 0, 0, 64'h0,    1, 0);
        add(1, 0, 0, 64'h0,      0, 0, 1, 64'hA000,    0, 0, 0, 0, 0, 64'h0,    1, 0);
        add(1, 0, 0, 64'h0,      0, 0, 0, 64'h0,       0, 0, 0, 1, 0, 64'hA000, 1, 0);
        add(1, 0, 0, 64'h0,      0, 0, 1, 64'hDEAD,    0, 1, 1, 0, 0, 64'h0,    1, 0);
        add(1, 0, 0, 64'h0,      0, 0, 0, 64'h0,       0, 0, 0, 0, 0, 64'h0,    1, 0);
        add(1, 0, 0, 64'h0,      0, 0, 0, 64'h0,       0, 0, 0, 0, 0, 64'h0,    1, 0);
        add(0, 0, 0, 64'h0,      0, 0, 0, 64'h0,       0, 0, 0, 0, 0, 64'h0,    1, 0);
        add(1, 0, 0, 64'h0,      0, 0, 0, 64'h0,       0, 0, 0, 0, 0, 64'h0,    0, 0);
        add(1, 0, 0, 64'h0,      0, 0, 0, 64'h0,       0, 0, 0, 0, 0, 64'h0,    0, 0);

        for (int i = 0; i < vq.size(); i++) begin
            tick();
            reset_n = vq[i].rst_n; recovery_req = vq[i].req; commit_valid = vq[i].cv;
            commit_pc = vq[i].cpc; exception_flag = vq[i].exc; stq_count = vq[i].stq;
            t_rdv = vq[i].rdv; t_rdd = vq[i].rdd;
            @(negedge clk);
            act = {flush_o, arch_rd_req, arch_rd_idx, rf_we, rf_waddr, rf_wdata,
                   mem_sync_req, restart_valid, busy, double_fault, restart_pc};
            exp = {vq[i].e_flush, vq[i].e_rdreq, vq[i].e_idx, vq[i].e_we, vq[i].e_waddr,
                   vq[i].e_wdata, 1'b0, 1'b0, vq[i].e_busy, vq[i].e_df, 64'h0};
            chk_w($sformatf("vec%0d", i), act, exp);
        end
        t_rdv = 1'b0; recovery_req = 1'b0; commit_valid = 1'b0; exception_flag = 1'b0;
        gold_en = 1'b1; ack_en = 1'b0;
        tick();
        ack_en = 1'b1;

        // Basic recovery with a delayed quiesce.
        commit_valid = 1'b1; commit_pc = 64'h400100; tick();
        commit_valid = 1'b0; commit_pc = '0;
        w0 = wr_addr_q.size(); r0 = n_restart; df0 = n_df; f0 = n_flush; m0 = n_ms;
        recovery_req = 1'b1; tick(); recovery_req = 1'b0;
        exception_flag = 1'b1; stq_count = 5'd2; repeat (4) tick();
        stq_count = '0; s_cyc = cyc;
        wait_restart(400, r0, ok);
        exception_flag = 1'b0;
        chk("basic_restart_seen", 64'(ok), 64'd1);
        chk("basic_flush_cycle", 64'(flush_cyc - s_cyc), 64'd1);
        chk("basic_flush_count", 64'(n_flush - f0), 64'd1);
        chk("basic_restart_latency", 64'(restart_cyc - flush_cyc), 64'(3*NUM_REGS + 3));
        chk("basic_restart_pc", last_rpc, 64'h400100);
        chk("basic_memsync_cycles", 64'(n_ms - m0), 64'd2);
        check_writes(w0, "basic");
        repeat (3) tick();
        chk("basic_restart_count", 64'(n_restart - r0), 64'd1);
        chk("basic_restart_pc_hold", restart_pc, 64'h400100);
        chk("basic_idle", 64'(busy), 64'd0);
        chk("basic_no_df", 64'(n_df - df0), 64'd0);

        // Random golden-source latency.
        lat_rand = 1'b1;
        w0 = wr_addr_q.size(); r0 = n_restart; v0 = n_rdviol;
        exception_flag = 1'b1; stq_count = '0;
        recovery_req = 1'b1; tick(); recovery_req = 1'b0;
        wait_restart(1200, r0, ok);
        exception_flag = 1'b0; lat_rand = 1'b0;
        chk("varlat_restart_seen", 64'(ok), 64'd1);
        chk("varlat_read_overlap", 64'(n_rdviol - v0), 64'd0);
        check_writes(w0, "varlat");

        // Double faults in PENDING and in RD_WAIT.
        lat_fixed = 3; repeat (2) tick();
        w0 = wr_addr_q.size(); r0 = n_restart; df0 = n_df;
        recovery_req = 1'b1; tick(); recovery_req = 1'b0; tick();
        recovery_req = 1'b1; tick(); recovery_req = 1'b0;
        exception_flag = 1'b1; stq_count = '0;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (arch_rd_req && arch_rd_idx == 6'd5) begin
                found = 1'b1;
                break;
            end
        end
        chk("dfault_reached_idx5", 64'(found), 64'd1);
        tick(); recovery_req = 1'b1; tick(); recovery_req = 1'b0;
        wait_restart(800, r0, ok);
        exception_flag = 1'b0;
        repeat (5) tick();
        chk("dfault_restart_seen", 64'(ok), 64'd1);
        chk("dfault_pulses", 64'(n_df - df0), 64'd2);
        chk("dfault_one_restart", 64'(n_restart - r0), 64'd1);
        check_writes(w0, "dfault");
        lat_fixed = 1;

        // Reset in the middle of the register restore.
        w0 = wr_addr_q.size(); r0 = n_restart;
        exception_flag = 1'b1; stq_count = '0;
        recovery_req = 1'b1; tick(); recovery_req = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rf_we && rf_waddr == 6'd10) begin
                found = 1'b1;
                break;
            end
        end
        chk("midrst_reached_idx10", 64'(found), 64'd1);
        @(posedge clk); #1;
        reset_n = 1'b0; exception_flag = 1'b0;
        chk("midrst_writes_before", 64'(wr_addr_q.size() - w0), 64'd11);
        w0 = wr_addr_q.size(); m0 = n_ms;
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (60) tick();
        chk("midrst_no_more_writes", 64'(wr_addr_q.size() - w0), 64'd0);
        chk("midrst_no_memsync", 64'(n_ms - m0), 64'd0);
        chk("midrst_no_restart", 64'(n_restart - r0), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_restart_pc", restart_pc, 64'h0);

        // PC tracking while pending and after the flush.
        r0 = n_restart;
        recovery_req = 1'b1; tick(); recovery_req = 1'b0;
        commit_valid = 1'b1; commit_pc = 64'h400200; tick();
        commit_pc = 64'h400204; tick();
        commit_valid = 1'b0; exception_flag = 1'b1; stq_count = '0; tick();
        exception_flag = 1'b0;
        commit_valid = 1'b1; commit_pc = 64'h400300; tick(); tick();
        commit_valid = 1'b0; commit_pc = '0;
        wait_restart(400, r0, ok);
        chk("pctrack_restart_seen", 64'(ok), 64'd1);
        chk("pctrack_restart_pc", last_rpc, 64'h400204);
        repeat (4) tick();
        chk("pctrack_restart_pc_stable", restart_pc, 64'h400204);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
